multi_cycle_comp: RTL
=====================

# multi_cycle_comp

Parametrised magnitude comparator for two WIDTH-bit operands. Each cycle it compares one CHUNK-bit slice, starting at the most-significant slice, and stops at the first unequal slice. A per-request mode selects unsigned or two's-complement signed comparison. It is the next generation of the team's fixed-width combinational comparators, used where wide operands must not form a long combinational compare chain; requests and results use valid/ready handshakes.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (derived), WIDTH/CHUNK: number of slices.
- CW (derived), $clog2(NCHUNK+1): width of out_chunks.
- clk  input  1  single clock; everything is sampled on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- eq  output  1  A == B.
- lt  output  1  A < B.
- gt  output  1  A > B.
- out_chunks  output  CW  number of slices examined, 1..NCHUNK.

## Operation
- The state machine has three states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - in_ready = 1 (forced to 0 while rst is high).
  - On in_valid & in_ready, register in_a and in_b, set idx = NCHUNK-1 and count = 0, then go to RUN.
  - In signed mode, bit WIDTH-1 of both registered operands is inverted at capture. The remainder of the compare is then unsigned.
- **RUN**
  - Each cycle compares slice [idx*CHUNK +: CHUNK] of A and B as unsigned values, and count increments.
  - Slices unequal: set lt or gt from that slice, go to DONE.
  - Slices equal and idx == 0: set eq, go to DONE.
  - Slices equal and idx > 0: decrement idx, stay in RUN.
- **DONE**
  - out_valid = 1.
  - Exactly one of eq/lt/gt is 1.
  - out_chunks = count.
  - On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid is ignored there; operands are not captured.
- eq, lt, gt and out_chunks are 0 whenever out_valid is 0.
- Results are registered and stay stable while out_valid & ~out_ready.
- Reset values: in_ready 0 during reset and 1 after release; out_valid, eq, lt, gt, out_chunks all 0.
- A rst assertion in any state drops the request and any pending result immediately. No output is produced for it.
- When NCHUNK = 1, RUN always lasts exactly one cycle.

## Timing
- Capture occurs at rising edge E0 (in_valid & in_ready).
- Slice k of the compare is evaluated at edge E0+k, for k = 1..n, where n is the number of slices examined.
- out_valid rises after edge E0+n, where n = out_chunks. Latency is 1..NCHUNK cycles, and the worst case is equal operands (n = NCHUNK).
- Results are accepted at the first edge where out_valid & out_ready. in_ready is 1 in the following cycle.
- The earliest next capture is one cycle after acceptance. There is no request/result overlap.
- Minimum throughput is one request per n+2 cycles.
- No combinational path runs from in_valid or out_ready to any output. in_ready depends only on state and rst.

## Test plan
- **Unsigned, differ in last slice.** WIDTH=32, CHUNK=4, unsigned, A=0x12345678, B=0x12345679 → lt=1, out_chunks=8, out_valid 8 cycles after capture.
- **Sign sensitivity.** A=0x80000000, B=0x00000001:
  - unsigned → gt=1, out_chunks=1;
  - signed → lt=1, out_chunks=1.
  - Also signed A=0xFFFFFFFF (-1), B=0xFFFFFFFE (-2) → gt=1, out_chunks=8.
- **Equal operands.** A=B=0xDEADBEEF, both modes → eq=1, out_chunks=8, latency 8.
- **Backpressure.** After out_valid, hold out_ready=0 for 5 cycles while pulsing in_valid with new operands. Required response:
  - results and out_chunks stay constant;
  - in_ready stays 0 and the new operands are not captured;
  - after out_ready=1, the next request is accepted the following cycle.
- **Reset mid-run.** Assert rst 3 cycles after capturing A=B=0 (still in RUN) → out_valid never rises, all outputs 0 immediately. After release, in_ready=1 and a fresh request A=5, B=3 → gt=1.
- **Alternate instance.** WIDTH=8, CHUNK=4, unsigned:
  - A=0xFE, B=0xEF → gt=1, out_chunks=1;
  - A=0x01, B=0x10 → lt=1, out_chunks=1;
  - A=0x01, B=0x00 → gt=1, out_chunks=2.

Source files
------------

// File: rtl/multi_cycle_comp_if.sv
// Request/result handshake bundle for multi_cycle_comp.
// The master side issues operands and accepts results; the slave side is the comparator.
interface multi_cycle_comp_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [CW-1:0]    out_chunks;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, eq, lt, gt, out_chunks
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, eq, lt, gt, out_chunks
    );
endinterface

// File: rtl/multi_cycle_comp.sv
// Sequential magnitude comparator: one CHUNK-bit slice per cycle, MSB slice first,
// stopping at the first unequal slice. Signed mode is reduced to unsigned by flipping the MSB.
module multi_cycle_comp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    multi_cycle_comp_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK + 1);
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [IW-1:0]    r_idx, w_idx_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic             r_eq, w_eq_next;
    logic             r_lt, w_lt_next;
    logic             r_gt, w_gt_next;

    logic [CHUNK-1:0] w_slice_a;
    logic [CHUNK-1:0] w_slice_b;
    logic [WIDTH-1:0] w_sign_mask;
    logic             w_out_valid;

    // Operands are shifted left as slices retire, so the active slice is always on top.
    assign w_slice_a   = r_a[WIDTH-1 -: CHUNK];
    assign w_slice_b   = r_b[WIDTH-1 -: CHUNK];
    assign w_sign_mask = WIDTH'(bus.in_signed) << (WIDTH - 1);

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_idx_next   = r_idx;
        w_count_next = r_count;
        w_eq_next    = r_eq;
        w_lt_next    = r_lt;
        w_gt_next    = r_gt;

        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_a_next     = bus.in_a ^ w_sign_mask;
                    w_b_next     = bus.in_b ^ w_sign_mask;
                    w_idx_next   = IW'(NCHUNK - 1);
                    w_count_next = '0;
                    w_eq_next    = 1'b0;
                    w_lt_next    = 1'b0;
                    w_gt_next    = 1'b0;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_count_next = r_count + CW'(1);
                if (w_slice_a != w_slice_b) begin
                    w_lt_next    = (w_slice_a < w_slice_b);
                    w_gt_next    = (w_slice_a > w_slice_b);
                    w_state_next = StDone;
                end else if (r_idx == '0) begin
                    w_eq_next    = 1'b1;
                    w_state_next = StDone;
                end else begin
                    w_idx_next = r_idx - IW'(1);
                    w_a_next   = r_a << CHUNK;
                    w_b_next   = r_b << CHUNK;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_eq_next    = 1'b0;
                    w_lt_next    = 1'b0;
                    w_gt_next    = 1'b0;
                    w_count_next = '0;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_idx   <= w_idx_next;
            r_count <= w_count_next;
            r_eq    <= w_eq_next;
            r_lt    <= w_lt_next;
            r_gt    <= w_gt_next;
        end
    end

    assign w_out_valid    = (r_state == StDone);
    assign bus.in_ready   = (r_state == StIdle) & ~rst;
    assign bus.out_valid  = w_out_valid;
    assign bus.eq         = r_eq & w_out_valid;
    assign bus.lt         = r_lt & w_out_valid;
    assign bus.gt         = r_gt & w_out_valid;
    assign bus.out_chunks = w_out_valid ? r_count : '0;
endmodule
